uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial transmitter that consumes the memory-mapped UART registers the core exports (io_uart_io_reg, io_uart_csr_reg) and drives an 8N1 line.
- Sits directly downstream of the core at the SoC top level, in the same clock domain.
- Software writes a byte to the UART IO word, then toggles the CSR request bit. The block detects the toggle, serialises the byte, and reports progress on status outputs.

Parameters:
- CLKS_PER_BIT, 16, default clock cycles per serial bit; legal range 2..65535.
- DIV_W, 16, width of the baud counter and of the CSR divisor field.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- io_uart_io_reg  in  32  UART data word from core; bits [7:0] = byte to send
- io_uart_csr_reg  in  32  UART control word from core; bit0 = tx_req toggle, bit1 = tx_en, bits[31:16] = baud divisor override
- tx  out  1  serial line, idle high
- tx_busy  out  1  high while a frame is in flight
- tx_ack  out  1  toggles once each time a request is accepted
- tx_count  out  16  number of frames fully sent, wraps at 65535->0

Behaviour:
- Reset (async assert, sync release by clk edge): state=IDLE, tx=1, tx_busy=0, tx_ack=0, tx_count=0, shifter=0, baud counter=0, bit index=0.
- Request definition: pending = (io_uart_csr_reg[0] != tx_ack) && io_uart_csr_reg[1]. Inputs are in the clk domain; no synchroniser.
- Effective divisor: div = csr[31:16] when csr[31:16] >= 2, else CLKS_PER_BIT.
- Latching:
  - Byte and div are sampled on the accepting edge and held for the whole frame.
  - Changes to the inputs mid-frame have no effect on that frame.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, tx_busy=0.
  - If pending at edge N: latch byte and div, flip tx_ack, clear the baud counter, go to START.
  - From edge N, tx=0 and tx_busy=1; both are registered outputs.
- START:
  - tx=0 for exactly div cycles.
  - Then DATA with bit index 0.
- DATA:
  - tx=shifter[0]; each bit is held div cycles, then the shifter shifts right and the index increments.
  - After bit 7, go to STOP. LSB first.
- STOP:
  - tx=1 for div cycles.
  - At the end, increment tx_count.
  - If pending, go directly to START, accepting the new request on the same edge (back-to-back, no idle gap). Otherwise go to IDLE.
- Frame length is exactly 10*div cycles, from the first tx=0 cycle to the last stop cycle.
- Baud counter counts 0..div-1. The bit boundary is at count == div-1. Width is DIV_W and it never overflows.
- Boundary conditions:
  - tx_en deasserted mid-frame: the current frame completes; no new request is accepted while tx_en=0.
  - Request bit toggled twice while busy: mismatch is cleared, so the second request is lost. This is by design; software must poll tx_ack.
  - Request toggled while busy once: it stays pending and is accepted at the end of STOP.
  - Async reset mid-frame: tx returns to 1 immediately, tx_count returns to 0, and any partial frame is abandoned.
  - tx_count is 65535 at the end of a frame: it wraps to 0.
  - div override changes between frames: it takes effect on the next accepted frame only.

Decomposition:
- Shared package next_uart_pkg:
  - state enum uart_tx_state_e {IDLE, START, DATA, STOP}
  - CSR bit constants UART_CSR_REQ_BIT=0, UART_CSR_EN_BIT=1, UART_CSR_DIV_LSB=16, UART_CSR_DIV_MSB=31
  - UART_IDLE_LEVEL=1
- One sub-module, uart_baud_gen:
  - Inputs: clk, rst, clear, div.
  - Output: bit_end, a single-cycle pulse at count == div-1.
  - Reusable by a future uart_rx.

Test Plan (CLKS_PER_BIT=4):
- Single byte: io=0x55, csr 0x0->0x3 → tx_ack=1 one cycle later. tx levels are 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles). Then tx_busy=0 and tx_count=1.
- Divisor override: csr=0x00080003, io=0xA5 → every bit is 8 cycles, frame is 80 cycles, data bits are 1,0,1,0,0,1,0,1.
- Back-to-back: io=0x00; toggle req; toggle again at cycle 20 with io=0xFF → the second start bit follows the first stop bit with no idle cycle. Total 80 cycles busy, tx_count=2, tx_ack=0.
- Disable gating:
  - csr=0x1 (tx_en=0) → tx stays 1 and tx_ack stays 0 for 100 cycles.
  - Then set tx_en=1 → the frame starts on the next cycle.
  - Clearing tx_en at cycle 12 of a frame still completes all 40 cycles.
- Async reset at cycle 17 of a frame → tx=1, tx_busy=0, tx_ack=0, tx_count=0 in the same cycle without a clock edge. With csr[0]=1 held, a fresh full frame starts after release.
- Mid-frame data change: change io from 0x55 to 0x0F at cycle 10 → the transmitted bits still match 0x55.

Source files
------------

// File: rtl/next_uart_pkg.sv
// Shared UART definitions: transmitter FSM states, CSR field positions, line idle level.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package next_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  localparam int   UART_CSR_REQ_BIT = 0;
  localparam int   UART_CSR_EN_BIT  = 1;
  localparam int   UART_CSR_DIV_LSB = 16;
  localparam int   UART_CSR_DIV_MSB = 31;

  localparam logic UART_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..div-1 and pulses bit_end on the last count of each bit.
// Latency: bit_end is combinational from the count register; first pulse div cycles after clear.
// Backpressure: none; clear holds the count at zero.
//
// Ports:
//   clk, rst  - clock, async active-high reset
//   clear     - synchronous clear; also suppresses bit_end
//   div       - cycles per bit, caller guarantees >= 2
//   bit_end   - single-cycle pulse at count == div-1
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_last;

  // Wraps at div-1, so with div >= 2 the counter never reaches its maximum.
  assign w_last  = (r_cnt == (div - DIV_W'(1)));
  assign bit_end = w_last && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by the core's memory-mapped UART IO/CSR words.
// Latency: a pending request is accepted on the next edge; tx drops low from that edge; a frame is 10*div cycles.
// Backpressure: one frame in flight; a toggle seen while busy waits until the end of STOP. Software polls tx_ack.
//
// Ports:
//   clk, rst         - clock, async active-high reset
//   io_uart_io_reg   - [7:0] byte to send
//   io_uart_csr_reg  - [0] request toggle, [1] enable, [31:16] divisor override (used when >= 2)
//   tx               - serial line, idle high
//   tx_busy          - high while a frame is in flight
//   tx_ack           - toggles on each accepted request
//   tx_count         - frames completed, wrapping
module uart_tx
  import next_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_W        = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_uart_io_reg,
  input  logic [31:0] io_uart_csr_reg,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_ack,
  output logic [15:0] tx_count
);

  uart_tx_state_e   r_state, w_state_nxt;
  logic             r_tx, w_tx_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ack, w_ack_nxt;
  logic [15:0]      r_count, w_count_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;

  logic             w_pending;
  logic             w_accept;
  logic             w_bit_end;
  logic [15:0]      w_csr_div;
  logic [DIV_W-1:0] w_div_sel;
  logic             w_unused_bits;

  assign w_pending = (io_uart_csr_reg[UART_CSR_REQ_BIT] != r_ack) &&
                     io_uart_csr_reg[UART_CSR_EN_BIT];

  assign w_csr_div = io_uart_csr_reg[UART_CSR_DIV_MSB:UART_CSR_DIV_LSB];
  // Overrides of 0 or 1 would make a bit shorter than the counter can express.
  assign w_div_sel = (w_csr_div >= 16'd2) ? DIV_W'(w_csr_div) : DIV_W'(CLKS_PER_BIT);

  assign w_unused_bits = ^{io_uart_io_reg[31:8], io_uart_csr_reg[15:2]};

  // Counter is parked at zero while idle so START always gets a full bit period.
  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (r_state == IDLE),
    .div     (r_div),
    .bit_end (w_bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= UART_IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
      r_count <= '0;
      r_shift <= '0;
      r_idx   <= '0;
      r_div   <= DIV_W'(CLKS_PER_BIT);
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= w_ack_nxt;
      r_count <= w_count_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_div   <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_ack_nxt   = r_ack;
    w_count_nxt = r_count;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_div_nxt   = r_div;
    w_accept    = 1'b0;

    case (r_state)
      IDLE: begin
        w_tx_nxt = UART_IDLE_LEVEL;
        w_accept = w_pending;
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = UART_IDLE_LEVEL;
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + 3'd1;
            w_tx_nxt    = w_shift_nxt[0];
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_count_nxt = r_count + 16'd1;
          w_state_nxt = IDLE;
          w_tx_nxt    = UART_IDLE_LEVEL;
          // A request seen during the frame starts the next one with no idle gap.
          w_accept    = w_pending;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = UART_IDLE_LEVEL;
      end
    endcase

    if (w_accept) begin
      w_state_nxt = START;
      w_tx_nxt    = 1'b0;
      w_ack_nxt   = ~r_ack;
      w_shift_nxt = io_uart_io_reg[7:0];
      w_div_nxt   = w_div_sel;
    end

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign tx       = r_tx;
  assign tx_busy  = r_busy;
  assign tx_ack   = r_ack;
  assign tx_count = r_count;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with CLKS_PER_BIT=4: frames are compared against a line-level model.
// Latency: expects tx low one cycle after a request appears, 10*div cycles per frame.
// Backpressure: exercises back-to-back, disable gating, double toggle, async reset and divisor changes.
module tb_uart_tx;

  logic        clk;
  logic        rst;
  logic [31:0] io_uart_io_reg;
  logic [31:0] io_uart_csr_reg;
  logic        tx;
  logic        tx_busy;
  logic        tx_ack;
  logic [15:0] tx_count;

  int          vectors;
  int          miscompares;
  logic        m_ack;
  logic [15:0] m_count;

  uart_tx #(
    .CLKS_PER_BIT (4),
    .DIV_W        (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .io_uart_io_reg  (io_uart_io_reg),
    .io_uart_csr_reg (io_uart_csr_reg),
    .tx              (tx),
    .tx_busy         (tx_busy),
    .tx_ack          (tx_ack),
    .tx_count        (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_csr(input logic [15:0] d, input logic en, input logic req);
    return {d, 14'b0, en, req};
  endfunction

  // Line levels of an 8N1 frame, index 0 = start bit, LSB first, index 9 = stop bit.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic int eff_div(input logic [15:0] d);
    return (d >= 16'd2) ? int'(d) : 4;
  endfunction

  // Called at a negedge. Waits (bounded) for tx low, then samples 10*div cycles.
  // wait_cyc counts negedges waited (-1 on timeout); returns at the negedge after the frame.
  task automatic capture_frame(input int div, output logic [9:0] lv, output logic stable,
                               output logic busy_ok, output int wait_cyc);
    lv = '1; stable = 1'b1; busy_ok = 1'b1; wait_cyc = 0;
    while (tx !== 1'b0 && wait_cyc < 400) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (tx !== 1'b0) begin
      wait_cyc = -1;
      return;
    end
    for (int k = 0; k < 10 * div; k++) begin
      if (k % div == 0) lv[k / div] = tx;
      else if (tx !== lv[k / div]) stable = 1'b0;
      if (tx_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; io_uart_io_reg = '0; io_uart_csr_reg = '0;
    m_ack = 1'b0; m_count = '0;
    #2;
    vectors++;
    if ({tx, tx_busy, tx_ack, tx_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_async: got tx=%b busy=%b ack=%b cnt=%0d want 1 0 0 0", tx, tx_busy, tx_ack, tx_count);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tx, tx_busy, tx_ack, tx_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_idle: got tx=%b busy=%b ack=%b cnt=%0d want 1 0 0 0", tx, tx_busy, tx_ack, tx_count);
    end
  endtask

  task automatic test_single;
    logic [9:0] lv; logic st, bo; int w;
    @(posedge clk); #1;
    io_uart_io_reg = 32'h55; io_uart_csr_reg = mk_csr(16'd0, 1'b1, ~m_ack);
    @(negedge clk);
    capture_frame(4, lv, st, bo, w);
    m_ack = ~m_ack; m_count = m_count + 16'd1;
    vectors++;
    if (lv !== frame_of(8'h55) || w != 1) begin
      miscompares++;
      $display("FAIL single_frame: got levels=%b wait=%0d want %b wait=1", lv, w, frame_of(8'h55));
    end
    vectors++;
    if (!st || !bo) begin
      miscompares++;
      $display("FAIL single_timing: got stable=%b busy=%b want 1 1", st, bo);
    end
    vectors++;
    if ({tx_busy, tx_ack, tx_count} !== {1'b0, m_ack, m_count}) begin
      miscompares++;
      $display("FAIL single_status: got busy=%b ack=%b cnt=%0d want 0 %b %0d", tx_busy, tx_ack, tx_count, m_ack, m_count);
    end
  endtask

  task automatic test_div_override;
    logic [9:0] lv; logic st, bo; int w;
    @(posedge clk); #1;
    io_uart_io_reg = 32'hA5; io_uart_csr_reg = mk_csr(16'd8, 1'b1, ~m_ack);
    @(negedge clk);
    capture_frame(8, lv, st, bo, w);
    m_ack = ~m_ack; m_count = m_count + 16'd1;
    vectors++;
    if (lv !== frame_of(8'hA5) || w != 1 || !st || !bo) begin
      miscompares++;
      $display("FAIL div8_frame: got levels=%b wait=%0d stable=%b busy=%b want %b 1 1 1", lv, w, st, bo, frame_of(8'hA5));
    end
    vectors++;
    if ({tx_busy, tx_ack, tx_count} !== {1'b0, m_ack, m_count}) begin
      miscompares++;
      $display("FAIL div8_status: got busy=%b ack=%b cnt=%0d want 0 %b %0d", tx_busy, tx_ack, tx_count, m_ack, m_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] lv1, lv2; logic st1, bo1, st2, bo2; int w1, w2;
    @(posedge clk); #1;
    io_uart_io_reg = 32'h00; io_uart_csr_reg = mk_csr(16'd0, 1'b1, ~m_ack);
    @(negedge clk);
    fork
      begin
        capture_frame(4, lv1, st1, bo1, w1);
        capture_frame(4, lv2, st2, bo2, w2);
      end
      begin
        repeat (20) @(posedge clk);
        #1 io_uart_io_reg = 32'hFF;
        io_uart_csr_reg[0] = ~io_uart_csr_reg[0];
      end
    join
    m_count = m_count + 16'd2;
    vectors++;
    if (lv1 !== frame_of(8'h00) || lv2 !== frame_of(8'hFF)) begin
      miscompares++;
      $display("FAIL b2b_frames: got %b %b want %b %b", lv1, lv2, frame_of(8'h00), frame_of(8'hFF));
    end
    vectors++;
    if (w1 != 1 || w2 != 0 || !st1 || !st2 || !bo1 || !bo2) begin
      miscompares++;
      $display("FAIL b2b_gap: got wait=%0d/%0d stable=%b%b busy=%b%b want 1/0 11 11", w1, w2, st1, st2, bo1, bo2);
    end
    vectors++;
    if ({tx_busy, tx_ack, tx_count} !== {1'b0, m_ack, m_count}) begin
      miscompares++;
      $display("FAIL b2b_status: got busy=%b ack=%b cnt=%0d want 0 %b %0d", tx_busy, tx_ack, tx_count, m_ack, m_count);
    end
  endtask

  task automatic test_async_reset;
    int w;
    logic [9:0] lv; logic st, bo;
    // Relies on tx_ack being 0 here so that csr[0]=1 is a request both before and after reset.
    @(posedge clk); #1;
    io_uart_io_reg = 32'h3C; io_uart_csr_reg = mk_csr(16'd0, 1'b1, 1'b1);
    w = 0;
    while (tx !== 1'b0 && w < 50) begin @(negedge clk); w++; end
    repeat (17) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({tx, tx_busy, tx_ack, tx_count} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      miscompares++;
      $display("FAIL async_reset: got tx=%b busy=%b ack=%b cnt=%0d want 1 0 0 0", tx, tx_busy, tx_ack, tx_count);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ack = 1'b1; m_count = 16'd1;
    @(negedge clk);
    capture_frame(4, lv, st, bo, w);
    vectors++;
    if (lv !== frame_of(8'h3C) || w != 1 || !st || !bo) begin
      miscompares++;
      $display("FAIL async_restart: got levels=%b wait=%0d stable=%b busy=%b want %b 1 1 1", lv, w, st, bo, frame_of(8'h3C));
    end
    vectors++;
    if ({tx_ack, tx_count} !== {m_ack, m_count}) begin
      miscompares++;
      $display("FAIL async_status: got ack=%b cnt=%0d want %b %0d", tx_ack, tx_count, m_ack, m_count);
    end
  endtask

  task automatic test_disable;
    logic [9:0] lv; logic st, bo, ok; int w;
    logic [7:0] b;
    b = 8'($urandom);
    @(posedge clk); #1;
    io_uart_io_reg = {24'h0, b}; io_uart_csr_reg = mk_csr(16'd0, 1'b0, ~m_ack);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_ack !== m_ack || tx_busy !== 1'b0) ok = 1'b0;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL disabled_idle: got a transition while tx_en=0 (tx=%b ack=%b) want tx=1 ack=%b", tx, tx_ack, m_ack);
    end
    @(posedge clk); #1 io_uart_io_reg[31:8] = 24'hDEAD00;
    io_uart_csr_reg[1] = 1'b1;
    @(negedge clk);
    fork
      capture_frame(4, lv, st, bo, w);
      begin
        repeat (12) @(posedge clk);
        #1 io_uart_csr_reg[1] = 1'b0;
        io_uart_csr_reg[0] = ~io_uart_csr_reg[0];
      end
    join
    m_ack = ~m_ack; m_count = m_count + 16'd1;
    vectors++;
    if (lv !== frame_of(b) || w != 1 || !st || !bo) begin
      miscompares++;
      $display("FAIL disable_midframe: got levels=%b wait=%0d stable=%b busy=%b want %b 1 1 1", lv, w, st, bo, frame_of(b));
    end
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ack !== m_ack) ok = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (!ok || tx_count !== m_count) begin
      miscompares++;
      $display("FAIL disable_no_accept: got ok=%b cnt=%0d want 1 %0d", ok, tx_count, m_count);
    end
    @(posedge clk); #1 io_uart_csr_reg = mk_csr(16'd0, 1'b1, m_ack);
  endtask

  task automatic test_double_toggle;
    logic [9:0] lv; logic st, bo, ok; int w;
    @(posedge clk); #1;
    io_uart_io_reg = 32'h96; io_uart_csr_reg = mk_csr(16'd0, 1'b1, ~m_ack);
    @(negedge clk);
    fork
      capture_frame(4, lv, st, bo, w);
      begin
        repeat (10) @(posedge clk); #1 io_uart_csr_reg[0] = ~io_uart_csr_reg[0];
        repeat (5)  @(posedge clk); #1 io_uart_csr_reg[0] = ~io_uart_csr_reg[0];
      end
    join
    m_ack = ~m_ack; m_count = m_count + 16'd1;
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    vectors++;
    if (lv !== frame_of(8'h96) || !ok || tx_ack !== m_ack || tx_count !== m_count) begin
      miscompares++;
      $display("FAIL double_toggle: got levels=%b idle=%b ack=%b cnt=%0d want %b 1 %b %0d", lv, ok, tx_ack, tx_count, frame_of(8'h96), m_ack, m_count);
    end
  endtask

  task automatic test_midframe_data;
    logic [9:0] lv; logic st, bo; int w;
    @(posedge clk); #1;
    io_uart_io_reg = 32'h55; io_uart_csr_reg = mk_csr(16'd0, 1'b1, ~m_ack);
    @(negedge clk);
    fork
      capture_frame(4, lv, st, bo, w);
      begin repeat (10) @(posedge clk); #1 io_uart_io_reg = 32'h0F; end
    join
    m_ack = ~m_ack; m_count = m_count + 16'd1;
    vectors++;
    if (lv !== frame_of(8'h55) || w != 1 || !st || tx_count !== m_count) begin
      miscompares++;
      $display("FAIL midframe_data: got levels=%b cnt=%0d want %b %0d", lv, tx_count, frame_of(8'h55), m_count);
    end
  endtask

  task automatic test_random;
    logic [9:0] lv; logic st, bo; int w, d;
    logic [7:0] b; logic [15:0] ovr;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 5))
        0: ovr = 16'd0;
        1: ovr = 16'd1;
        2: ovr = 16'd2;
        3: ovr = 16'd3;
        4: ovr = 16'd5;
        default: ovr = 16'd7;
      endcase
      d = eff_div(ovr);
      @(posedge clk); #1;
      io_uart_io_reg = {24'($urandom), b};
      io_uart_csr_reg = mk_csr(ovr, 1'b1, ~m_ack) | ($urandom & 32'h0000_FFFC);
      @(negedge clk);
      capture_frame(d, lv, st, bo, w);
      m_ack = ~m_ack; m_count = m_count + 16'd1;
      vectors++;
      if (lv !== frame_of(b) || w != 1 || !st || !bo) begin
        miscompares++;
        $display("FAIL rand_frame[%0d]: got levels=%b wait=%0d stable=%b busy=%b want %b 1 1 1 (div=%0d)", n, lv, w, st, bo, frame_of(b), d);
      end
      vectors++;
      if ({tx_busy, tx_ack, tx_count} !== {1'b0, m_ack, m_count}) begin
        miscompares++;
        $display("FAIL rand_status[%0d]: got busy=%b ack=%b cnt=%0d want 0 %b %0d", n, tx_busy, tx_ack, tx_count, m_ack, m_count);
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_div_override();
    test_back_to_back();
    test_async_reset();
    test_disable();
    test_double_toggle();
    test_midframe_data();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
